// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode constants for the pipelined MIPS core.
//   - opcode / funct encodings of the base and extended instruction sets
//   - TYPE_W and one-hot bit indices of the instruction classes (err on top)
//   - TUSE_NONE, the "operand never read" Tuse value
//   - id_slot_t, the decoded contents of the IF/ID register (PC kept apart
//     because its width is a parameter of the stage)
package cpu_pkg;

  localparam int TYPE_W = 18;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // One-hot class bit positions in itype
  localparam int IT_ADDU  = 0;
  localparam int IT_SUBU  = 1;
  localparam int IT_SLL   = 2;
  localparam int IT_JR    = 3;
  localparam int IT_ORI   = 4;
  localparam int IT_LW    = 5;
  localparam int IT_SW    = 6;
  localparam int IT_BEQ   = 7;
  localparam int IT_LUI   = 8;
  localparam int IT_J     = 9;
  localparam int IT_JAL   = 10;
  localparam int IT_JALR  = 11;
  localparam int IT_SLT   = 12;
  localparam int IT_AND   = 13;
  localparam int IT_OR    = 14;
  localparam int IT_BNE   = 15;
  localparam int IT_ADDIU = 16;
  localparam int IT_ERR   = 17;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef logic [TYPE_W-1:0] itype_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    itype_t      itype;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    logic [1:0]  tuse_rs;
    logic [1:0]  tuse_rt;
    logic [1:0]  tnew;
    logic        ri;
  } id_slot_t;

  // Empty ID slot: no class, no destination, reads no operands.
  function automatic id_slot_t bubble_slot();
    id_slot_t s;
    s         = '0;
    s.tuse_rs = TUSE_NONE;
    s.tuse_rt = TUSE_NONE;
    return s;
  endfunction

endpackage

// File: rtl/instr_class_dec.sv
// instr_class_dec: purely combinational instruction classifier.
//   Parameter EXT_EN : 1 decodes jalr/slt/and/or/bne/addiu, 0 sends them to err.
//   instr   in  32      instruction word
//   itype   out TYPE_W  one-hot class (exactly one bit set, err if unknown)
//   wa      out 5       destination register, 0 when nothing is written
//   tuse_rs out 2       cycles until rs is needed (3 = never)
//   tuse_rt out 2       cycles until rt is needed (3 = never)
//   tnew    out 2       cycles until the result exists, 0 when wa is 0
module instr_class_dec
  import cpu_pkg::*;
#(
  parameter int EXT_EN = 1
) (
  input  logic [31:0]       instr,
  output logic [TYPE_W-1:0] itype,
  output logic [4:0]        wa,
  output logic [1:0]        tuse_rs,
  output logic [1:0]        tuse_rt,
  output logic [1:0]        tnew
);

  localparam bit EXT_OK = (EXT_EN != 0);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  // rs and shamt play no part in classification.
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    itype = '0;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_ADDU: itype[IT_ADDU] = 1'b1;
        FN_SUBU: itype[IT_SUBU] = 1'b1;
        FN_SLL:  itype[IT_SLL]  = 1'b1;
        FN_JR:   itype[IT_JR]   = 1'b1;
        FN_JALR: itype[IT_JALR] = EXT_OK;
        FN_SLT:  itype[IT_SLT]  = EXT_OK;
        FN_AND:  itype[IT_AND]  = EXT_OK;
        FN_OR:   itype[IT_OR]   = EXT_OK;
        default: itype = '0;
      endcase
    end else begin
      case (op)
        OP_ORI:   itype[IT_ORI]   = 1'b1;
        OP_LW:    itype[IT_LW]    = 1'b1;
        OP_SW:    itype[IT_SW]    = 1'b1;
        OP_BEQ:   itype[IT_BEQ]   = 1'b1;
        OP_LUI:   itype[IT_LUI]   = 1'b1;
        OP_J:     itype[IT_J]     = 1'b1;
        OP_JAL:   itype[IT_JAL]   = 1'b1;
        OP_BNE:   itype[IT_BNE]   = EXT_OK;
        OP_ADDIU: itype[IT_ADDIU] = EXT_OK;
        default:  itype = '0;
      endcase
    end
    // Anything unrecognised, including extended ops when disabled, is err.
    if (itype == '0) itype[IT_ERR] = 1'b1;
  end

  // Class groups used by the timing tables.
  logic r_alu, dst_rd, dst_rt, dst_31, br_cmp;
  logic [4:0] wa_raw;

  assign r_alu  = itype[IT_ADDU] | itype[IT_SUBU] | itype[IT_SLT] |
                  itype[IT_AND]  | itype[IT_OR];
  assign dst_rd = r_alu | itype[IT_SLL] | itype[IT_JALR];
  assign dst_rt = itype[IT_ORI] | itype[IT_LUI] | itype[IT_ADDIU] | itype[IT_LW];
  assign dst_31 = itype[IT_JAL];
  assign br_cmp = itype[IT_BEQ] | itype[IT_BNE];

  always_comb begin
    wa_raw = 5'd0;
    if (dst_rd)      wa_raw = rd;
    else if (dst_rt) wa_raw = rt;
    else if (dst_31) wa_raw = 5'd31;
  end

  // Writing $0 is no write at all, so it must not create a hazard.
  assign wa = wa_raw;

  always_comb begin
    tuse_rs = TUSE_NONE;
    if (br_cmp | itype[IT_JR] | itype[IT_JALR])
      tuse_rs = 2'd0;
    else if (r_alu | itype[IT_ORI] | itype[IT_ADDIU] | itype[IT_LW] | itype[IT_SW])
      tuse_rs = 2'd1;

    tuse_rt = TUSE_NONE;
    if (br_cmp)                     tuse_rt = 2'd0;
    else if (r_alu | itype[IT_SLL]) tuse_rt = 2'd1;
    else if (itype[IT_SW])          tuse_rt = 2'd2;

    tnew = 2'd0;
    if (wa_raw != 5'd0) begin
      if (itype[IT_LW])
        tnew = 2'd3;
      else if (itype[IT_JAL] | itype[IT_JALR])
        tnew = 2'd1;
      else if (r_alu | itype[IT_ORI] | itype[IT_ADDIU] | itype[IT_LUI] | itype[IT_SLL])
        tnew = 2'd2;
    end
  end

endmodule

// File: rtl/decode_stage_reg.sv
// decode_stage_reg: D-stage front end. Decodes the fetched instruction and
// registers it, with its hazard timing, at the IF/ID boundary.
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   en                 load enable (0 = stall, register holds)
//   flush              load a bubble at the next edge (beats a stall)
//   f_valid/f_instr/f_pc  fetch slot
//   d_valid/d_instr/d_pc  registered slot
//   d_itype            one-hot class, zero for a bubble
//   d_rs, d_rt, d_wa   register fields and destination
//   d_tuse_rs/rt, d_tnew  hazard timing
//   d_ri               reserved instruction (err class in a valid slot)
// Handshake: no valid/ready pair here; a slot is consumed every edge on which
// en=1, and f_valid=0 on such an edge loads a bubble. All outputs are flops.
module decode_stage_reg
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter int              EXT_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              f_valid,
  input  logic [31:0]       f_instr,
  input  logic [PC_W-1:0]   f_pc,
  output logic              d_valid,
  output logic [31:0]       d_instr,
  output logic [PC_W-1:0]   d_pc,
  output logic [TYPE_W-1:0] d_itype,
  output logic [4:0]        d_rs,
  output logic [4:0]        d_rt,
  output logic [4:0]        d_wa,
  output logic [1:0]        d_tuse_rs,
  output logic [1:0]        d_tuse_rt,
  output logic [1:0]        d_tnew,
  output logic              d_ri
);

  logic [TYPE_W-1:0] dec_itype;
  logic [4:0]        dec_wa;
  logic [1:0]        dec_tuse_rs;
  logic [1:0]        dec_tuse_rt;
  logic [1:0]        dec_tnew;

  instr_class_dec #(.EXT_EN(EXT_EN)) u_dec (
    .instr   (f_instr),
    .itype   (dec_itype),
    .wa      (dec_wa),
    .tuse_rs (dec_tuse_rs),
    .tuse_rt (dec_tuse_rt),
    .tnew    (dec_tnew)
  );

  id_slot_t        slot_d, slot_q;
  logic [PC_W-1:0] pc_d, pc_q;
  id_slot_t        load_slot;

  always_comb begin
    load_slot         = '0;
    load_slot.valid   = 1'b1;
    load_slot.instr   = f_instr;
    load_slot.itype   = dec_itype;
    load_slot.rs      = f_instr[25:21];
    load_slot.rt      = f_instr[20:16];
    load_slot.wa      = dec_wa;
    load_slot.tuse_rs = dec_tuse_rs;
    load_slot.tuse_rt = dec_tuse_rt;
    load_slot.tnew    = dec_tnew;
    load_slot.ri      = dec_itype[IT_ERR];
  end

  // Priority below reset: flush > hold > load.
  always_comb begin
    slot_d = slot_q;
    pc_d   = pc_q;
    if (flush) begin
      slot_d = bubble_slot();
      pc_d   = RESET_PC;
    end else if (en) begin
      if (f_valid) begin
        slot_d = load_slot;
        pc_d   = f_pc;
      end else begin
        slot_d = bubble_slot();
        pc_d   = RESET_PC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= bubble_slot();
      pc_q   <= RESET_PC;
    end else begin
      slot_q <= slot_d;
      pc_q   <= pc_d;
    end
  end

  assign d_valid   = slot_q.valid;
  assign d_instr   = slot_q.instr;
  assign d_pc      = pc_q;
  assign d_itype   = slot_q.itype;
  assign d_rs      = slot_q.rs;
  assign d_rt      = slot_q.rt;
  assign d_wa      = slot_q.wa;
  assign d_tuse_rs = slot_q.tuse_rs;
  assign d_tuse_rt = slot_q.tuse_rt;
  assign d_tnew    = slot_q.tnew;
  assign d_ri      = slot_q.ri;

endmodule

// File: tb/tb_decode_stage_reg.sv
module tb_decode_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [17:0] itype;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wa;
    logic [1:0]  tuse_rs;
    logic [1:0]  tuse_rt;
    logic [1:0]  tnew;
    logic        ri;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b1, flush = 1'b0, f_valid = 1'b0;
  logic [31:0] f_instr = '0, f_pc = '0;

  logic        d1_valid, d0_valid, d1_ri, d0_ri;
  logic [31:0] d1_instr, d0_instr, d1_pc, d0_pc;
  logic [17:0] d1_itype, d0_itype;
  logic [4:0]  d1_rs, d1_rt, d1_wa, d0_rs, d0_rt, d0_wa;
  logic [1:0]  d1_tuse_rs, d1_tuse_rt, d1_tnew, d0_tuse_rs, d0_tuse_rt, d0_tnew;

  decode_stage_reg #(.PC_W(32), .RESET_PC(32'h0000_3000), .EXT_EN(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .f_valid(f_valid),
    .f_instr(f_instr), .f_pc(f_pc), .d_valid(d1_valid), .d_instr(d1_instr),
    .d_pc(d1_pc), .d_itype(d1_itype), .d_rs(d1_rs), .d_rt(d1_rt), .d_wa(d1_wa),
    .d_tuse_rs(d1_tuse_rs), .d_tuse_rt(d1_tuse_rt), .d_tnew(d1_tnew), .d_ri(d1_ri)
  );

  decode_stage_reg #(.PC_W(32), .RESET_PC(32'h0000_3000), .EXT_EN(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .f_valid(f_valid),
    .f_instr(f_instr), .f_pc(f_pc), .d_valid(d0_valid), .d_instr(d0_instr),
    .d_pc(d0_pc), .d_itype(d0_itype), .d_rs(d0_rs), .d_rt(d0_rt), .d_wa(d0_wa),
    .d_tuse_rs(d0_tuse_rs), .d_tuse_rt(d0_tuse_rt), .d_tnew(d0_tnew), .d_ri(d0_ri)
  );

  exp_t got1, got0;
  assign got1 = {d1_valid, d1_instr, d1_pc, d1_itype, d1_rs, d1_rt, d1_wa,
                 d1_tuse_rs, d1_tuse_rt, d1_tnew, d1_ri};
  assign got0 = {d0_valid, d0_instr, d0_pc, d0_itype, d0_rs, d0_rt, d0_wa,
                 d0_tuse_rs, d0_tuse_rt, d0_tnew, d0_ri};

  // ---------------- reference model ----------------
  // Class index order: addu subu sll jr ori lw sw beq lui j jal
  //                    jalr slt and or bne addiu err
  logic [31:0] enc_tab [18] = '{32'h0000_0021, 32'h0000_0023, 32'h0000_0000,
    32'h0000_0008, 32'h3400_0000, 32'h8c00_0000, 32'hac00_0000, 32'h1000_0000,
    32'h3c00_0000, 32'h0800_0000, 32'h0c00_0000, 32'h0000_0009, 32'h0000_002a,
    32'h0000_0024, 32'h0000_0025, 32'h1400_0000, 32'h2400_0000, 32'hfc00_0000};
  // destination: 0 none, 1 rd, 2 rt, 3 r31
  int dst_tab  [18] = '{1,1,1,0,2,2,0,0,2,0,3,1,1,1,1,0,2,0};
  int trs_tab  [18] = '{1,1,3,0,1,1,1,0,3,3,3,0,1,1,1,0,1,3};
  int trt_tab  [18] = '{1,1,1,3,3,3,2,0,3,3,3,3,1,1,1,0,3,3};
  int tnew_tab [18] = '{2,2,2,0,2,3,0,0,2,0,1,1,2,2,2,0,2,0};
  int is_ext   [18] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,0};

  function automatic int classify(logic [31:0] ins, bit ext);
    for (int k = 0; k < 17; k++) begin
      logic [31:0] e;
      e = enc_tab[k];
      if (k >= 11 && !ext && is_ext[k] == 1) continue;
      if (ins[31:26] == e[31:26] && (ins[31:26] != 6'd0 || ins[5:0] == e[5:0]))
        return k;
    end
    return 17;
  endfunction

  function automatic exp_t bubble();
    exp_t s;
    s = '0;
    s.pc = 32'h0000_3000;
    s.tuse_rs = 2'd3;
    s.tuse_rt = 2'd3;
    return s;
  endfunction

  function automatic exp_t model_dec(logic [31:0] ins, logic [31:0] pc, bit ext);
    exp_t s;
    int k;
    k = classify(ins, ext);
    s = '0;
    s.valid = 1'b1;
    s.instr = ins;
    s.pc = pc;
    s.itype = 18'(1) << k;
    s.rs = ins[25:21];
    s.rt = ins[20:16];
    case (dst_tab[k])
      1: s.wa = ins[15:11];
      2: s.wa = ins[20:16];
      3: s.wa = 5'd31;
      default: s.wa = 5'd0;
    endcase
    s.tuse_rs = 2'(trs_tab[k]);
    s.tuse_rt = 2'(trt_tab[k]);
    s.tnew = (s.wa == 5'd0) ? 2'd0 : 2'(tnew_tab[k]);
    s.ri = (k == 17);
    return s;
  endfunction

  function automatic logic [31:0] make_instr(int k);
    logic [31:0] r;
    r = $urandom;
    if (k != 17 && enc_tab[k][31:26] == 6'd0)
      return enc_tab[k] | {6'd0, r[25:6], 6'd0};
    return enc_tab[k] | {6'd0, r[25:0]};
  endfunction

  // ---------------- scoreboard ----------------
  exp_t exp1_q[$];
  exp_t exp0_q[$];
  exp_t m1, m0;
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic e, input logic fl, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc);
    reset = r; en = e; flush = fl; f_valid = v; f_instr = ins; f_pc = pc;
    if (r || fl) begin
      m1 = bubble(); m0 = bubble();
    end else if (e) begin
      m1 = v ? model_dec(ins, pc, 1'b1) : bubble();
      m0 = v ? model_dec(ins, pc, 1'b0) : bubble();
    end
    exp1_q.push_back(m1);
    exp0_q.push_back(m0);
    @(posedge clk);
    #3;
  endtask

  task automatic load(input logic [31:0] ins);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, ins, 32'h0000_3000 + ($urandom_range(0, 4095) << 2));
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (exp1_q.size() > 0) check("slot_ext1", 128'(got1), 128'(exp1_q.pop_front()));
      if (exp0_q.size() > 0) check("slot_ext0", 128'(got0), 128'(exp0_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    m1 = bubble();
    m0 = bubble();

    // Reset with a valid lui waiting at the input.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h3c01_1234, 32'h0000_3004);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h3c01_1234, 32'h0000_3004);
    check("rst_pc", 128'(d1_pc), 128'(32'h3000));
    check("rst_valid", 128'(d1_valid), 128'(0));
    check("rst_tuse_rs", 128'(d1_tuse_rs), 128'(3));
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h3c01_1234, 32'h0000_3004);
    check("lui_itype", 128'(d1_itype), 128'(18'h00100));
    check("lui_wa", 128'(d1_wa), 128'(1));
    check("lui_tnew", 128'(d1_tnew), 128'(2));
    check("lui_valid", 128'(d1_valid), 128'(1));

    // Decode sweep over every class, both extension settings.
    for (int k = 0; k < 18; k++) begin
      load(make_instr(k));
      check("sweep_itype_ext1", 128'(d1_itype), 128'(18'(1) << k));
      check("sweep_ri_ext0", 128'(d0_ri), 128'((k >= 11) ? 1 : 0));
    end
    load(32'h8c22_0004);
    check("lw_wa", 128'(d1_wa), 128'(2));
    check("lw_tnew", 128'(d1_tnew), 128'(3));
    check("lw_tuse_rs", 128'(d1_tuse_rs), 128'(1));

    // Stall holds everything while the fetch side keeps changing.
    load(32'hac22_0008);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, $urandom, $urandom);
      check("stall_tuse_rt", 128'(d1_tuse_rt), 128'(2));
      check("stall_instr", 128'(d1_instr), 128'(32'hac22_0008));
    end

    // Flush beats stall.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h1022_fffe, 32'h0000_3100);
    check("flush_valid", 128'(d1_valid), 128'(0));
    check("flush_itype", 128'(d1_itype), 128'(0));

    // jal and nop.
    load(32'h0c00_0c00);
    check("jal_wa", 128'(d1_wa), 128'(31));
    check("jal_tnew", 128'(d1_tnew), 128'(1));
    load(32'h0000_0000);
    check("nop_itype", 128'(d1_itype), 128'(18'h00004));
    check("nop_wa", 128'(d1_wa), 128'(0));
    check("nop_tnew", 128'(d1_tnew), 128'(0));
    check("nop_valid", 128'(d1_valid), 128'(1));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = ($urandom_range(0, 7) == 0) ? $urandom : make_instr($urandom_range(0, 17));
      cycle(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) != 0), ins, $urandom);
    end

    // Asynchronous reset between edges.
    load(32'h0022_1821);
    #1 reset = 1'b1;
    #1;
    check("async_valid", 128'(d1_valid), 128'(0));
    check("async_pc", 128'(d1_pc), 128'(32'h3000));
    check("async_itype", 128'(d1_itype), 128'(0));
    check("async_wa", 128'(d1_wa), 128'(0));
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0022_1821, 32'h0000_3200);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0022_1821, 32'h0000_3204);
    check("post_rst_wa", 128'(d1_wa), 128'(3));

    @(posedge clk);
    #4;
    check("drain_q", 128'(exp1_q.size() + exp0_q.size()), 128'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
